// File: rtl/blk_en_pkg.sv
// Shared widths and types for the 6-to-64 cache block-enable decoder.
package blk_en_pkg;

    localparam int unsigned SET_W      = 6;
    localparam int unsigned NUM_BLOCKS = 64;
    localparam int unsigned GRP_W      = 3;
    localparam int unsigned GRP_LINES  = 8;

    typedef logic [SET_W-1:0]      set_idx_t;
    typedef logic [NUM_BLOCKS-1:0] blk_en_t;
    typedef logic [GRP_W-1:0]      grp_sel_t;
    typedef logic [GRP_LINES-1:0]  grp_dec_t;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input blk_en_t v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            multi = multi | (seen & v[i]);
            seen  = seen | v[i];
        end
        return seen & ~multi;
    endfunction

endpackage

// File: rtl/block_enable_6to64_decoder3to8.sv
// 3-to-8 one-hot predecoder used for the high and low index groups.
module decoder3to8
    import blk_en_pkg::*;
(
    input  logic [GRP_W-1:0]     sel_i,
    output logic [GRP_LINES-1:0] dec_c
);

    always_comb begin
        dec_c        = '0;
        dec_c[sel_i] = 1'b1;
    end

endmodule

// File: rtl/block_enable_6to64.sv
// 6-bit set index to 64-bit one-hot block enable, plus a registered capture path.
// Optional sticky one-hot checker enabled by defining BLKEN_ONEHOT_CHECK_EN.
module block_enable_6to64
    import blk_en_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SET_W-1:0]      setBits,
    input  logic                  en,
    output logic [NUM_BLOCKS-1:0] blockEnable,
    output logic [NUM_BLOCKS-1:0] blockEnable_q,
    output logic [SET_W-1:0]      setBits_q,
    output logic                  valid_q
`ifdef BLKEN_ONEHOT_CHECK_EN
    ,
    output logic                  onehot_err
`endif
);

    grp_dec_t hi_dec;
    grp_dec_t lo_dec;

    blk_en_t  blk_en_d;
    set_idx_t set_d;
    logic     valid_d;

    decoder3to8 u_dec_hi (
        .sel_i (setBits[SET_W-1:GRP_W]),
        .dec_c (hi_dec)
    );

    decoder3to8 u_dec_lo (
        .sel_i (setBits[GRP_W-1:0]),
        .dec_c (lo_dec)
    );

    // Row select: lane 8*h+l fires when both group predecodes agree.
    for (genvar h = 0; h < GRP_LINES; h++) begin : g_hi
        for (genvar l = 0; l < GRP_LINES; l++) begin : g_lo
            assign blockEnable[h*GRP_LINES + l] = hi_dec[h] & lo_dec[l];
        end
    end

    always_comb begin
        blk_en_d = blockEnable_q;
        set_d    = setBits_q;
        valid_d  = valid_q;
        if (en) begin
            blk_en_d = blockEnable;
            set_d    = setBits;
            valid_d  = 1'b1;
        end
    end

    // Decode and index are loaded together so blockEnable_q always matches setBits_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blockEnable_q <= '0;
            setBits_q     <= '0;
            valid_q       <= 1'b0;
        end else begin
            blockEnable_q <= blk_en_d;
            setBits_q     <= set_d;
            valid_q       <= valid_d;
        end
    end

`ifdef BLKEN_ONEHOT_CHECK_EN
    logic onehot_err_d;

    always_comb begin
        onehot_err_d = onehot_err | ~is_onehot(blockEnable);
    end

    // Sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_err <= 1'b0;
        end else begin
            onehot_err <= onehot_err_d;
        end
    end

    onehot_chk: assert property (@(posedge clk) disable iff (!rst_n) is_onehot(blockEnable))
        else $error("blockEnable not one-hot: %h", blockEnable);
`endif

endmodule

// File: tb/tb_block_enable_6to64.sv
// Self-checking bench for block_enable_6to64: directed decodes, exhaustive sweep,
// reset/hold behaviour and randomized capture against a shift-based reference.
module tb_block_enable_6to64;

    logic        clk;
    logic        rst_n;
    logic [5:0]  setBits;
    logic        en;
    logic [63:0] blockEnable;
    logic [63:0] blockEnable_q;
    logic [5:0]  setBits_q;
    logic        valid_q;
`ifdef BLKEN_ONEHOT_CHECK_EN
    logic        onehot_err;
`endif

    int unsigned checks;
    int unsigned passed;

    logic [63:0] exp_q;
    logic [5:0]  exp_set;
    logic        exp_valid;

    block_enable_6to64 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .setBits       (setBits),
        .en            (en),
        .blockEnable   (blockEnable),
        .blockEnable_q (blockEnable_q),
        .setBits_q     (setBits_q),
        .valid_q       (valid_q)
`ifdef BLKEN_ONEHOT_CHECK_EN
        ,
        .onehot_err    (onehot_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_dec(input logic [5:0] idx);
        logic [63:0] one;
        one = 64'd1;
        return one << idx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_be_q"}, blockEnable_q, exp_q);
        chk({tag, "_set_q"}, 64'(setBits_q), 64'(exp_set));
        chk({tag, "_valid_q"}, 64'(valid_q), 64'(exp_valid));
    endtask

    task automatic model_reset();
        exp_q     = '0;
        exp_set   = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_edge();
        if (en) begin
            exp_q     = ref_dec(setBits);
            exp_set   = setBits;
            exp_valid = 1'b1;
        end
    endtask

    logic [5:0]  dir_idx [6];
    logic [63:0] dir_exp [6];

    initial begin
        checks  = 0;
        passed  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        setBits = '0;
        model_reset();

        dir_idx[0] = 6'd0;  dir_exp[0] = 64'h0000_0000_0000_0001;
        dir_idx[1] = 6'd1;  dir_exp[1] = 64'h0000_0000_0000_0002;
        dir_idx[2] = 6'd10; dir_exp[2] = 64'h0000_0000_0000_0400;
        dir_idx[3] = 6'd32; dir_exp[3] = 64'h0000_0001_0000_0000;
        dir_idx[4] = 6'd63; dir_exp[4] = 64'h8000_0000_0000_0000;
        dir_idx[5] = 6'd21; dir_exp[5] = 64'h0000_0000_0020_0000;

        // Reset state and combinational decode while held in reset.
        #2;
        chk_regs("reset");
        for (int i = 0; i < 6; i++) begin
            setBits = dir_idx[i];
            #1;
            chk($sformatf("dir_%0d", dir_idx[i]), blockEnable, dir_exp[i]);
        end

        // Exhaustive sweep.
        for (int i = 0; i < 64; i++) begin
            setBits = 6'(i);
            #1;
            chk($sformatf("pop_%0d", i), 64'($countones(blockEnable)), 64'd1);
            chk($sformatf("bit_%0d", i), 64'(blockEnable[i]), 64'd1);
            chk($sformatf("sweep_%0d", i), blockEnable, ref_dec(6'(i)));
        end
        chk_regs("reset_after_sweep");

        // Release reset; first edge honours en.
        @(negedge clk);
        rst_n   = 1'b1;
        setBits = 6'd10;
        en      = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        chk("first_be_q", blockEnable_q, 64'h400);
        chk("first_set_q", 64'(setBits_q), 64'd10);
        chk("first_valid_q", 64'(valid_q), 64'd1);

        // Hold with en low.
        @(negedge clk);
        en      = 1'b0;
        setBits = 6'd63;
        #1;
        chk("hold_comb", blockEnable, 64'h8000_0000_0000_0000);
        chk("hold_be_q_pre", blockEnable_q, 64'h400);
        @(posedge clk);
        model_edge();
        #1;
        chk("hold_be_q_post", blockEnable_q, 64'h400);
        chk_regs("hold");

        // Alternating en: only en=1 cycles capture.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            setBits = 6'($urandom_range(0, 63));
            en      = ~i[0];
            @(posedge clk);
            model_edge();
            #1;
            chk_regs($sformatf("toggle_%0d", i));
        end

        // Randomized capture.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            setBits = 6'($urandom_range(0, 63));
            en      = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("rnd_comb_%0d", i), blockEnable, ref_dec(setBits));
            @(posedge clk);
            model_edge();
            #1;
            chk_regs($sformatf("rnd_%0d", i));
        end

        // Make sure registers hold nonzero state before the async reset.
        @(negedge clk);
        setBits = 6'd45;
        en      = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        chk_regs("pre_async");

        // Async reset between edges: clears without a clock edge.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_regs("async_rst");
        setBits = 6'd7;
        #1;
        chk("rst_comb_track", blockEnable, 64'h80);
        @(posedge clk);
        model_reset();
        #1;
        chk_regs("rst_held_edge");

        // Release and capture again.
        @(negedge clk);
        rst_n   = 1'b1;
        setBits = 6'd55;
        en      = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        chk_regs("post_rst_capture");
        chk("post_rst_be_q", blockEnable_q, 64'h0080_0000_0000_0000);

`ifdef BLKEN_ONEHOT_CHECK_EN
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            setBits = 6'(i);
        end
        @(posedge clk);
        #1;
        chk("onehot_err", 64'(onehot_err), 64'd0);
`endif

        @(negedge clk);
        en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/block_enable_6to64.md
# block_enable_6to64

Decodes a 6-bit cache set index into a 64-bit one-hot block-enable vector: exactly one bit is high, the bit whose position equals the index. It sits between the address split logic and the 64-entry tag/data/valid arrays of the cache, where each array line uses its enable bit as a row select. The decode path is purely combinational. A registered copy of the decode, with an index/valid capture, is provided for pipelined array access.

## Interface
- No parameters. Widths are fixed: SET_W = 6 and NUM_BLOCKS = 64, both from the shared package.
- clk  input  1  single clock for all registered outputs.
- rst_n  input  1  asynchronous, active-low reset.
- setBits  input  6  set index to decode.
- en  input  1  capture enable for the registered path only. It has no effect on blockEnable.
- blockEnable  output  64  combinational one-hot decode: blockEnable[i] = (setBits == i).
- blockEnable_q  output  64  registered copy of blockEnable, captured when en = 1.
- setBits_q  output  6  index captured alongside blockEnable_q.
- valid_q  output  1  high once a capture has occurred since reset.

## Operation
- blockEnable is a pure function of setBits. It has no dependence on clk, rst_n or en, so it must be correct with clk and rst_n unconnected.
- Exactly one bit of blockEnable is high for every legal setBits value 0..63. Bit 0 is the LSB.
- The decode is built as two 3-to-8 predecoders, one for setBits[5:3] (the high group) and one for setBits[2:0] (the low group). blockEnable[8*h + l] = hi[h] & lo[l].
- Registered path, on a rising clk edge with en = 1:
  - blockEnable_q <= blockEnable
  - setBits_q <= setBits
  - valid_q <= 1
- Registered path, on a rising clk edge with en = 0: all registers hold.
- Invariant: blockEnable_q always equals the one-hot decode of setBits_q, because both are loaded together.
- X/Z on setBits may propagate X to blockEnable. No recovery logic is required.

## Timing
- blockEnable: zero-cycle combinational latency from setBits.
- Registered outputs: one-cycle latency from setBits/en to blockEnable_q, setBits_q and valid_q.
- Reset (rst_n low) takes effect immediately, independent of clk:
  - blockEnable_q = 0 (all-zero, the only legal non-one-hot value)
  - setBits_q = 0
  - valid_q = 0
- Reset asserted mid-operation clears the registers at once. The combinational blockEnable keeps tracking setBits throughout reset.
- On the first clk edge after rst_n deasserts, en is honoured normally.
- When en toggles every cycle, only the cycles with en = 1 capture.

## Configuration
- BLKEN_ONEHOT_CHECK_EN defined:
  - Adds output onehot_err (1 bit), registered, reset value 0.
  - onehot_err is set on any clk edge where the combinational blockEnable is not exactly one-hot (popcount != 1).
  - It is sticky until rst_n asserts.
  - Simulation builds also emit $error on the same event.
- BLKEN_ONEHOT_CHECK_EN undefined: the port and the check logic are absent. All other behaviour is identical.

## Structure
- Shared package blk_en_pkg holds:
  - SET_W = 6 and NUM_BLOCKS = 64
  - a typedef for the set index (logic [SET_W-1:0])
  - a typedef for the enable vector (logic [NUM_BLOCKS-1:0])
- One natural sub-module, decoder3to8: a 3-bit input and an 8-bit one-hot output, instantiated twice for the high and low groups.
- Top level contains the 64-lane AND matrix, the capture registers and the optional one-hot checker.

## Test plan
- Combinational sweep with clk idle:
  - setBits = 0 -> blockEnable = 64'h0000_0000_0000_0001
  - setBits = 1 -> 64'h0000_0000_0000_0002
  - setBits = 10 -> 64'h0000_0000_0000_0400
- Upper-half and boundary decodes:
  - setBits = 32 -> 64'h0000_0001_0000_0000
  - setBits = 63 -> 64'h8000_0000_0000_0000
  - setBits = 21 -> 64'h0000_0000_0020_0000
- Exhaustive: for all 64 values, $countones(blockEnable) = 1 and blockEnable[setBits] = 1.
- Reset: hold rst_n low -> blockEnable_q = 0, setBits_q = 0, valid_q = 0. Release, drive setBits = 10 with en = 1, one edge later -> blockEnable_q = 64'h400, setBits_q = 10, valid_q = 1.
- Hold: en = 0, change setBits to 63 -> blockEnable = 64'h8000_0000_0000_0000 immediately, while blockEnable_q stays 64'h400.
- Async reset mid-operation: assert rst_n between clk edges -> registered outputs go to 0 with no clk edge. With BLKEN_ONEHOT_CHECK_EN defined, onehot_err stays 0 throughout a legal sweep.
